// File: rtl/bus_pkg.sv
// Shared definitions for the bus responder: FSM states, RW encoding and the
// value returned for reads that fall outside the decode window.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic       RW_READ       = 1'b1;
  localparam logic       RW_WRITE      = 1'b0;
  localparam logic [7:0] OPEN_BUS_DATA = 8'hFF;
  localparam int         CNT_W         = 4;

endpackage

// File: rtl/bus_resp_ram.sv
// Single-port byte RAM with registered read; contents are never reset.
module bus_resp_ram #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [0:(1<<AW)-1];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_responder.sv
// Wait-state bus responder backed by a local byte RAM.
// Define BUS_RESPONDER_MIRROR_EN to mirror the RAM four times across the window.
module bus_responder
  import bus_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          MEM_AW      = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] I_Addr,
  input  logic [7:0]  I_WData,
  input  logic        I_RW,
  input  logic        I_Cmd,
  output logic [7:0]  O_RData,
  output logic        O_Finish,
  output logic        O_Busy
);

`ifdef BUS_RESPONDER_MIRROR_EN
  localparam logic [16:0] WINDOW = 17'(4 << MEM_AW);
`else
  localparam logic [16:0] WINDOW = 17'(1 << MEM_AW);
`endif
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             rw_q, rw_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [7:0]       rdata_out;
  logic [15:0]      offset;
  logic             mapped;
  logic             ram_en, ram_we, finish;
  logic [7:0]       ram_rdata;

  // Wrapping subtraction makes addresses below BASE_ADDR land far outside the window.
  assign offset = addr_q - BASE_ADDR;
  assign mapped = {1'b0, offset} < WINDOW;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    rdata_d   = rdata_q;
    rdata_out = rdata_q;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (I_Cmd) begin
          addr_d  = I_Addr;
          wdata_d = I_WData;
          rw_d    = I_RW;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ram_en  = mapped;
        ram_we  = (rw_q == RW_WRITE);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        finish = 1'b1;
        if (rw_q == RW_READ) begin
          rdata_out = mapped ? ram_rdata : OPEN_BUS_DATA;
          rdata_d   = rdata_out;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= RW_READ;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
    end
  end

  bus_resp_ram #(.AW(MEM_AW)) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (offset[MEM_AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign O_RData  = rdata_out;
  assign O_Finish = finish;
  assign O_Busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: two instances (2 and 0 wait states) checked every
// cycle against a transaction-level model, plus directed literal checks.
`timescale 1ns/1ps
module tb_bus_responder;

  localparam int          NI    = 2;
  localparam int          W0    = 2;
  localparam int          W1    = 0;
  localparam logic [15:0] B0    = 16'h0000;
  localparam logic [15:0] B1    = 16'h6000;
  localparam int          AW    = 11;
  localparam int          DEPTH = 2048;
`ifdef BUS_RESPONDER_MIRROR_EN
  localparam int WIN    = 4 * DEPTH;
  localparam bit MIRROR = 1'b1;
`else
  localparam int WIN    = DEPTH;
  localparam bit MIRROR = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] addr  [NI];
  logic [7:0]  wdata [NI];
  logic        rw    [NI];
  logic        cmd   [NI];
  logic [7:0]  rdata [NI];
  logic        fin   [NI];
  logic        busy  [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_responder #(.WAIT_CYCLES(W0), .BASE_ADDR(B0), .MEM_AW(AW)) dut0 (
    .clk(clk), .rst_n(rst_n), .I_Addr(addr[0]), .I_WData(wdata[0]), .I_RW(rw[0]),
    .I_Cmd(cmd[0]), .O_RData(rdata[0]), .O_Finish(fin[0]), .O_Busy(busy[0])
  );

  bus_responder #(.WAIT_CYCLES(W1), .BASE_ADDR(B1), .MEM_AW(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .I_Addr(addr[1]), .I_WData(wdata[1]), .I_RW(rw[1]),
    .I_Cmd(cmd[1]), .O_RData(rdata[1]), .O_Finish(fin[1]), .O_Busy(busy[1])
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic int wait_of(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  function automatic logic [15:0] base_of(input int i);
    return (i == 0) ? B0 : B1;
  endfunction

  // ---------------- transaction-level reference model ----------------
  logic [7:0]  mem_m   [NI][DEPTH];
  bit          valid_m [NI][DEPTH];
  bit          pend_m  [NI];
  int          left_m  [NI];
  logic [15:0] a_m     [NI];
  logic [7:0]  d_m     [NI];
  logic        rw_m    [NI];
  logic [7:0]  hold_m  [NI];
  bit          known_m [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [15:0] o;
      int          off;
      bit          exp_fin, rd_known, was_pend;
      logic [7:0]  exp_rd;
      if (!rst_n) begin
        pend_m[i]  = 1'b0;
        hold_m[i]  = 8'h00;
        known_m[i] = 1'b1;
        chk("rst_finish", i, 32'(fin[i]), 32'd0);
        chk("rst_busy", i, 32'(busy[i]), 32'd0);
        chk("rst_rdata", i, 32'(rdata[i]), 32'h00);
      end else begin
        if (pend_m[i]) left_m[i]--;
        o   = a_m[i] - base_of(i);
        off = int'(o);
        if (pend_m[i] && left_m[i] == 1 && rw_m[i] == 1'b0 && off < WIN) begin
          mem_m[i][off % DEPTH]   = d_m[i];
          valid_m[i][off % DEPTH] = 1'b1;
        end
        exp_fin  = pend_m[i] && (left_m[i] == 0);
        exp_rd   = hold_m[i];
        rd_known = known_m[i];
        if (exp_fin && rw_m[i]) begin
          if (off >= WIN) begin
            exp_rd   = 8'hFF;
            rd_known = 1'b1;
          end else begin
            exp_rd   = mem_m[i][off % DEPTH];
            rd_known = valid_m[i][off % DEPTH];
          end
        end
        chk("finish", i, 32'(fin[i]), 32'(exp_fin));
        chk("busy", i, 32'(busy[i]), 32'(pend_m[i]));
        if (rd_known) chk("rdata", i, 32'(rdata[i]), 32'(exp_rd));
        was_pend = pend_m[i];
        if (exp_fin) begin
          pend_m[i] = 1'b0;
          if (rw_m[i]) begin
            hold_m[i]  = exp_rd;
            known_m[i] = rd_known;
          end
        end
        if (cmd[i] && !was_pend) begin
          pend_m[i] = 1'b1;
          left_m[i] = wait_of(i) + 2;
          a_m[i]    = addr[i];
          d_m[i]    = wdata[i];
          rw_m[i]   = rw[i];
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic xact(input int i, input logic [15:0] a, input logic r, input logic [7:0] d,
                      output int lat, output logic [7:0] rd);
    @(posedge clk); #1;
    addr[i] = a; rw[i] = r; wdata[i] = d; cmd[i] = 1'b1;
    lat = -1;
    rd  = 8'h00;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      cmd[i] = 1'b0;
      @(negedge clk);
      if (fin[i]) begin
        lat = n;
        rd  = rdata[i];
        break;
      end
    end
    $display("xact inst=%0d addr=%h rw=%0d wdata=%h lat=%0d rdata=%h", i, a, r, d, lat, rd);
  endtask

  function automatic logic [15:0] pick(input int i);
    logic [15:0] o;
    int s;
    s = $urandom_range(0, 7);
    o = 16'($urandom_range(0, 15));
    case (s)
      3:       o = o + 16'h0800;
      4:       o = o + 16'h1800;
      5:       o = o + 16'h2000;
      6:       o = o + 16'h4000;
      7:       o = 16'($urandom);
      default: ;
    endcase
    return o + base_of(i);
  endfunction

  initial begin
    int         lat, nfin;
    logic [7:0] rd;
    for (int i = 0; i < NI; i++) begin
      addr[i] = '0; wdata[i] = '0; rw[i] = 1'b1; cmd[i] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy_lit", 0, 32'(busy[0]), 32'd0);
    chk("reset_rdata_lit", 0, 32'(rdata[0]), 32'h00);
    @(posedge clk); #1 rst_n = 1'b1;

    // write then read back with two wait states
    xact(0, 16'h0123, 1'b0, 8'h5A, lat, rd);
    chk("wr_lat", 0, lat, 4);
    xact(0, 16'h0123, 1'b1, 8'h00, lat, rd);
    chk("rd_lat", 0, lat, 4);
    chk("rd_5a", 0, 32'(rd), 32'h5A);
    xact(0, 16'h0923, 1'b1, 8'h00, lat, rd);
    chk("mirror_rd", 0, 32'(rd), MIRROR ? 32'h5A : 32'hFF);

    // unmapped accesses leave RAM alone
    xact(0, 16'h0000, 1'b0, 8'h3C, lat, rd);
    xact(0, 16'h4000, 1'b0, 8'h11, lat, rd);
    chk("unmap_wr_lat", 0, lat, 4);
    xact(0, 16'h4000, 1'b1, 8'h00, lat, rd);
    chk("unmap_rd_lat", 0, lat, 4);
    chk("unmap_rd_ff", 0, 32'(rd), 32'hFF);
    xact(0, 16'h0000, 1'b1, 8'h00, lat, rd);
    chk("ram_unchanged", 0, 32'(rd), 32'h3C);

    // commands during WAIT and during DONE are dropped
    @(posedge clk); #1;
    addr[0] = 16'h0123; rw[0] = 1'b1; cmd[0] = 1'b1;
    nfin = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      rw[0] = 1'b0; wdata[0] = 8'hEE;
      cmd[0] = (n == 2 || n == 4);
      @(negedge clk);
      if (fin[0]) begin
        nfin++;
        chk("busy_rd_data", 0, 32'(rdata[0]), 32'h5A);
      end
    end
    chk("single_finish", 0, nfin, 1);
    xact(0, 16'h0123, 1'b1, 8'h00, lat, rd);
    chk("ignored_wr", 0, 32'(rd), 32'h5A);

    // reset during WAIT aborts a write
    xact(0, 16'h0010, 1'b0, 8'h42, lat, rd);
    @(posedge clk); #1;
    addr[0] = 16'h0010; rw[0] = 1'b0; wdata[0] = 8'h77; cmd[0] = 1'b1;
    @(posedge clk); #1;
    cmd[0] = 1'b0; rst_n = 1'b0;
    nfin = 0;
    for (int n = 0; n < 8; n++) begin
      if (n == 2) begin
        @(posedge clk); #1 rst_n = 1'b1;
      end
      @(negedge clk);
      if (fin[0]) nfin++;
    end
    chk("abort_no_finish", 0, nfin, 0);
    xact(0, 16'h0010, 1'b1, 8'h00, lat, rd);
    chk("abort_no_commit", 0, 32'(rd), 32'h42);

    // zero wait states, back-to-back reads
    xact(1, B1 + 16'h0005, 1'b0, 8'h99, lat, rd);
    chk("w0_wr_lat", 1, lat, 2);
    for (int k = 0; k < 4; k++) begin
      xact(1, B1 + 16'h0005, 1'b1, 8'h00, lat, rd);
      chk("w0_b2b_lat", 1, lat, 2);
      chk("w0_b2b_data", 1, 32'(rd), 32'h99);
    end

    // randomized traffic on both instances, checked by the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < NI; i++) begin
        cmd[i]   = ($urandom_range(0, 2) == 0);
        addr[i]  = pick(i);
        rw[i]    = 1'($urandom_range(0, 1));
        wdata[i] = 8'($urandom);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) cmd[i] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
